// File: rtl/wb_arb_pkg.sv
// Shared types and default address map for the Wishbone slave-select controller.
// The decode helper keeps the window-matching rule (and UART-first priority) in one place.
package wb_arb_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Slave selected for the current cycle
    typedef enum logic [1:0] {
        SLV_UART = 2'd0,
        SLV_BRAM = 2'd1,
        SLV_NONE = 2'd2
    } slv_idx_t;

    // Default user-area address map
    localparam logic [31:0] UART_BASE_DEF = 32'h3000_0000;
    localparam logic [31:0] UART_MASK_DEF = 32'hFFFF_0000;
    localparam logic [31:0] BRAM_BASE_DEF = 32'h3800_0000;
    localparam logic [31:0] BRAM_MASK_DEF = 32'hFFC0_0000;

    // Read data returned with any error response
    localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;

    // Master request as latched at the start of a cycle
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    // Window decode; UART wins if both windows match
    function automatic slv_idx_t decode_slave(
        input logic [31:0] adr,
        input logic [31:0] uart_base,
        input logic [31:0] uart_mask,
        input logic [31:0] bram_base,
        input logic [31:0] bram_mask
    );
        if ((adr & uart_mask) == uart_base) return SLV_UART;
        if ((adr & bram_mask) == bram_base) return SLV_BRAM;
        return SLV_NONE;
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// REQ-phase watchdog for wb_slave_arbiter.
// Present only when WB_ARB_TIMEOUT_EN is defined. 8-bit counter, cleared while
// not waiting on a slave, counting every waiting cycle; expired flags the
// terminal count LIMIT.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_timer #(
    parameter int unsigned LIMIT = 254
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT_Q = 8'(LIMIT);

    logic [7:0] cnt;

    // Count waiting cycles; never wraps because the controller leaves REQ at LIMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == LIMIT_Q);

endmodule
`endif

// File: rtl/wb_slave_arbiter.sv
// Registered Wishbone slave-select controller: management SoC port -> UART / BRAM.
// Decodes a master cycle into a slave window, drives that slave from latched
// request signals, and returns exactly one registered ack (with err for unmapped
// addresses or hung slaves).
// Optional feature macro: WB_ARB_TIMEOUT_EN adds the REQ timeout error path;
// without it REQ waits for the slave ack or a master abort.
module wb_slave_arbiter
    import wb_arb_pkg::*;
#(
    parameter logic [31:0] UART_BASE      = UART_BASE_DEF,
    parameter logic [31:0] UART_MASK      = UART_MASK_DEF,
    parameter logic [31:0] BRAM_BASE      = BRAM_BASE_DEF,
    parameter logic [31:0] BRAM_MASK      = BRAM_MASK_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    // master side
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        err_o,
    output logic        busy_o,
    // shared slave request
    output logic        slv_we_o,
    output logic [3:0]  slv_sel_o,
    output logic [31:0] slv_adr_o,
    output logic [31:0] slv_dat_o,
    // UART
    output logic        uart_cyc_o,
    output logic        uart_stb_o,
    input  logic        uart_ack_i,
    input  logic [31:0] uart_dat_i,
    // BRAM
    output logic        bram_cyc_o,
    output logic        bram_stb_o,
    input  logic        bram_ack_i,
    input  logic [31:0] bram_dat_i
);

    arb_state_t state;
    slv_idx_t   tgt;
    slv_idx_t   hit;
    wb_req_t    req_q;
    logic       uart_req;
    logic       bram_req;
    logic       sel_ack;
    logic [31:0] sel_dat;
    logic       tmo;

    assign hit = decode_slave(wbs_adr_i, UART_BASE, UART_MASK, BRAM_BASE, BRAM_MASK);

    // Route the selected slave's ack/data; the other slave is ignored entirely
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = 32'h0;
        case (tgt)
            SLV_UART: begin
                sel_ack = uart_ack_i;
                sel_dat = uart_dat_i;
            end
            SLV_BRAM: begin
                sel_ack = bram_ack_i;
                sel_dat = bram_dat_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Counter sits at zero outside REQ, so entering REQ always starts from 0
    wb_arb_timer #(
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .clear   (state != REQ),
        .enable  (state == REQ),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // State machine; in REQ an abort beats a same-cycle ack, which beats a timeout
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            tgt   <= SLV_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        tgt   <= hit;
                        state <= (hit == SLV_NONE) ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (sel_ack || tmo) begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the master request once per cycle; slaves see only the latched copy
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            req_q <= '0;
        end else if (state == IDLE && wbs_cyc_i && wbs_stb_i) begin
            req_q <= '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
        end
    end

    // Slave cyc/stb: raised on a window hit, dropped on ack, abort or timeout
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            uart_req <= 1'b0;
            bram_req <= 1'b0;
        end else if (state == IDLE) begin
            uart_req <= wbs_cyc_i && wbs_stb_i && (hit == SLV_UART);
            bram_req <= wbs_cyc_i && wbs_stb_i && (hit == SLV_BRAM);
        end else if (state == REQ && (!wbs_cyc_i || sel_ack || tmo)) begin
            uart_req <= 1'b0;
            bram_req <= 1'b0;
        end
    end

    // Master response: one-cycle ack/err, data held until the next response
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            err_o     <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i && hit == SLV_NONE) begin
                        wbs_ack_o <= 1'b1;
                        err_o     <= 1'b1;
                        wbs_dat_o <= ERR_DATA;
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        // abort: no response at all
                    end else if (sel_ack) begin
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= req_q.we ? 32'h0 : sel_dat;
                    end else if (tmo) begin
                        wbs_ack_o <= 1'b1;
                        err_o     <= 1'b1;
                        wbs_dat_o <= ERR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state != IDLE);
    assign slv_we_o   = req_q.we;
    assign slv_sel_o  = req_q.sel;
    assign slv_adr_o  = req_q.adr;
    assign slv_dat_o  = req_q.dat;
    assign uart_cyc_o = uart_req;
    assign uart_stb_o = uart_req;
    assign bram_cyc_o = bram_req;
    assign bram_stb_o = bram_req;

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Bench for wb_slave_arbiter: directed transfers with a response scoreboard.
// Expected responses are queued when a request is issued and popped by a monitor
// whenever the DUT acks; per-cycle strobe/busy expectations are checked inline.
module tb_wb_slave_arbiter;

    localparam int TMO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o, err_o, busy_o;
    logic [31:0] wbs_dat_o;
    logic        slv_we_o;
    logic [3:0]  slv_sel_o;
    logic [31:0] slv_adr_o, slv_dat_o;
    logic        uart_cyc_o, uart_stb_o, bram_cyc_o, bram_stb_o;
    logic        uart_ack_i = 1'b0, bram_ack_i = 1'b0;
    logic [31:0] uart_dat_i = 32'h0, bram_dat_i = 32'h0;

    wb_slave_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i   (wb_clk_i),   .wb_rst_n_i (wb_rst_n_i),
        .wbs_cyc_i  (wbs_cyc_i),  .wbs_stb_i  (wbs_stb_i),  .wbs_we_i (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),  .wbs_adr_i  (wbs_adr_i),  .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),  .wbs_dat_o  (wbs_dat_o),  .err_o (err_o), .busy_o (busy_o),
        .slv_we_o   (slv_we_o),   .slv_sel_o  (slv_sel_o),  .slv_adr_o (slv_adr_o), .slv_dat_o (slv_dat_o),
        .uart_cyc_o (uart_cyc_o), .uart_stb_o (uart_stb_o), .uart_ack_i (uart_ack_i), .uart_dat_i (uart_dat_i),
        .bram_cyc_o (bram_cyc_o), .bram_stb_o (bram_stb_o), .bram_ack_i (bram_ack_i), .bram_dat_i (bram_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every ack must match the oldest queued expectation
    exp_t mon_e;
    always @(negedge wb_clk_i) begin
        if (wbs_ack_o) begin
            if (sb.size() == 0) begin
                chk("unexp_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_cyc", 32'(cyc_cnt), 32'(mon_e.at));
                chk("rd_dat", wbs_dat_o, mon_e.dat);
                chk("err", 32'(err_o), 32'(mon_e.err));
            end
        end else if (err_o) begin
            chk("err_wo_ack", 32'd1, 32'd0);
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // tgt: 0 UART, 1 BRAM, 2 unmapped. ack_at/abort_at are cycle numbers, -1 = never.
    // stray: the non-selected slave acks throughout REQ with junk data.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input int tgt, input int ack_at,
                        input logic [31:0] rdat, input int abort_at, input bit stray);
        int   e;
        bit   is_abort, is_ack, is_err;
        exp_t x;
        if (tgt == 2) begin
            e = 0;
        end else begin
            e = 200;
            if (ack_at >= 1) e = ack_at;
            if (abort_at >= 1 && abort_at <= e) e = abort_at;
`ifdef WB_ARB_TIMEOUT_EN
            if (TMO < e) e = TMO;
`endif
        end
        is_abort = (tgt != 2) && (abort_at == e);
        is_ack   = (tgt != 2) && !is_abort && (ack_at == e);
        is_err   = !is_abort && !is_ack;
        if (!is_abort) begin
            x.dat = is_err ? 32'hDEAD_BEEF : (we ? 32'h0 : rdat);
            x.err = is_err;
            x.at  = cyc_cnt + e + 1;
            sb.push_back(x);
        end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
        for (int c = 0; c <= e + 2; c++) begin
            if (c == abort_at || c == e + 1) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            uart_ack_i = (tgt == 0 && c == ack_at) || (stray && tgt == 1 && c >= 1 && c <= e);
            bram_ack_i = (tgt == 1 && c == ack_at) || (stray && tgt == 0 && c >= 1 && c <= e);
            uart_dat_i = (tgt == 0) ? rdat : 32'hBAD0_0001;
            bram_dat_i = (tgt == 1) ? rdat : 32'hBAD0_0002;
            if (c >= 1) begin
                chk("uart_stb", 32'(uart_stb_o), 32'(tgt == 0 && c <= e));
                chk("bram_stb", 32'(bram_stb_o), 32'(tgt == 1 && c <= e));
                chk("uart_cyc", 32'(uart_cyc_o), 32'(tgt == 0 && c <= e));
                chk("bram_cyc", 32'(bram_cyc_o), 32'(tgt == 1 && c <= e));
                chk("busy", 32'(busy_o), 32'(c <= e || (c == e + 1 && !is_abort)));
                if (c == 1 && tgt != 2) begin
                    chk("slv_adr", slv_adr_o, adr);
                    chk("slv_dat", slv_dat_o, wdat);
                    chk("slv_sel", 32'(slv_sel_o), 32'(sel));
                    chk("slv_we", 32'(slv_we_o), 32'(we));
                end
            end
            tick();
        end
        uart_ack_i = 1'b0; bram_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ctl", 32'({wbs_ack_o, err_o, busy_o, uart_cyc_o, uart_stb_o,
                            bram_cyc_o, bram_stb_o, slv_we_o, slv_sel_o}), 32'h0);
        chk("rst_rdat", wbs_dat_o, 32'h0);
        chk("rst_adr", slv_adr_o, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        tick();
        tick();

        // BRAM read, ack 3 cycles after strobe, UART acking stray all along
        xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 1, 4, 32'h1234_5678, -1, 1'b1);
        // UART write, immediate ack
        xfer(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'b0001, 0, 1, 32'h5555_AAAA, -1, 1'b0);
        // Unmapped read
        xfer(1'b0, 32'h2000_0000, 32'h0, 4'hF, 2, -1, 32'h0, -1, 1'b0);
        // Window edges: last BRAM word, first addresses past each window
        xfer(1'b0, 32'h383F_FFFC, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, -1, 1'b0);
        xfer(1'b1, 32'h3840_0000, 32'h1111_2222, 4'hF, 2, -1, 32'h0, -1, 1'b0);
        xfer(1'b0, 32'h3001_0000, 32'h0, 4'hF, 2, -1, 32'h0, -1, 1'b0);
        // UART read with BRAM stray acks
        xfer(1'b0, 32'h3000_FFF0, 32'h0, 4'hF, 0, 3, 32'h0BAD_CAFE, -1, 1'b1);
        // Master abort at cycle 2 colliding with the UART ack
        xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 2, 32'h7777_7777, 2, 1'b0);
        // Read data holds through idle after a completed read
        chk("dat_hold", wbs_dat_o, 32'h0BAD_CAFE);

`ifdef WB_ARB_TIMEOUT_EN
        // Silent BRAM: error ack 8 cycles after REQ entry
        xfer(1'b0, 32'h3800_0100, 32'h0, 4'hF, 1, -1, 32'h0, -1, 1'b0);
        // Late BRAM ack in IDLE must be ignored
        bram_ack_i = 1'b1; bram_dat_i = 32'hFEED_0000;
        tick();
        bram_ack_i = 1'b0;
        chk("late_ack_busy", 32'(busy_o), 32'd0);
        tick();
        // Ack on the terminal-count cycle wins
        xfer(1'b0, 32'h3800_0104, 32'h0, 4'hF, 1, TMO, 32'h0A0B_0C0D, -1, 1'b0);
`endif
        // Next request after all of the above is serviced normally
        xfer(1'b0, 32'h3800_0200, 32'h0, 4'hF, 1, 1, 32'h2468_ACE0, -1, 1'b0);

        // Reset mid-REQ clears everything asynchronously
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3800_0020; wbs_dat_i = 32'h9999_8888; wbs_sel_i = 4'hF;
        tick();
        tick();
        chk("pre_rst_stb", 32'(bram_stb_o), 32'd1);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        chk("arst_ctl", 32'({wbs_ack_o, err_o, busy_o, uart_cyc_o, uart_stb_o,
                             bram_cyc_o, bram_stb_o, slv_we_o, slv_sel_o}), 32'h0);
        chk("arst_rdat", wbs_dat_o, 32'h0);
        chk("arst_adr", slv_adr_o, 32'h0);
        chk("arst_dat", slv_dat_o, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        tick();
        // Minimum-latency BRAM read after reset release
        xfer(1'b0, 32'h3800_0030, 32'h0, 4'hF, 1, 1, 32'h1357_9BDF, -1, 1'b0);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
